pipelined_adder: RTL and testbench

- Parametrised, pipelined successor to the team's single-bit half adder.
- Adds two WIDTH-bit operands plus a carry-in across STAGES register stages, each stage resolving one WIDTH/STAGES-bit chunk and passing its carry to the next.
- Uses a valid/ready handshake on both sides, so it can sit in streaming datapaths (accumulators, ALU front ends) at higher clock rates than a flat ripple adder.

---
 rtl/pipelined_adder.sv | 136 +++++++++++++
 tb/tb_pipelined_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder split into STAGES carry-chained chunks with valid/ready flow control.
// Optional feature macro: SUB_MODE_EN adds a 'sub' input selecting A - B - Cin.
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef SUB_MODE_EN
    input  logic             sub,
`endif
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] Y,
    output logic             Cout,
    output logic             V,
    output logic             valid_out,
    input  logic             ready_out
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             v_q;
    logic             v_d;

    assign advance  = !valid_out || ready_out;
    assign ready_in = advance;

`ifdef SUB_MODE_EN
    // A - B - Cin == A + ~B + ~Cin, so conditioning B and Cin on entry keeps every stage a plain adder.
    assign b_eff   = B ^ {WIDTH{sub}};
    assign cin_eff = Cin ^ sub;
`else
    assign b_eff   = B;
    assign cin_eff = Cin;
`endif

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int DONE = (gi + 1) * CHUNK;
            localparam int REM  = WIDTH - DONE;

            logic             valid_q;
            logic             valid_d;
            logic             carry_q;
            logic             c_in;
            logic             c_out;
            logic [DONE-1:0]  sum_q;
            logic [DONE-1:0]  sum_d;
            logic [CHUNK-1:0] a_c;
            logic [CHUNK-1:0] b_c;
            logic [CHUNK-1:0] s_c;

            if (gi == 0) begin : g_src
                assign a_c     = A[CHUNK-1:0];
                assign b_c     = b_eff[CHUNK-1:0];
                assign c_in    = cin_eff;
                assign valid_d = valid_in;
                assign sum_d   = s_c;
            end else begin : g_src
                // The low chunk of the previous stage's skew register is this stage's operand slice.
                assign a_c     = g_stage[gi-1].g_skew.a_q[CHUNK-1:0];
                assign b_c     = g_stage[gi-1].g_skew.b_q[CHUNK-1:0];
                assign c_in    = g_stage[gi-1].carry_q;
                assign valid_d = g_stage[gi-1].valid_q;
                assign sum_d   = {s_c, g_stage[gi-1].sum_q};
            end

            assign {c_out, s_c} = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, c_in};

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    carry_q <= 1'b0;
                    sum_q   <= '0;
                end else if (advance) begin
                    valid_q <= valid_d;
                    if (valid_d) begin
                        carry_q <= c_out;
                        sum_q   <= sum_d;
                    end
                end
            end

            if (REM > 0) begin : g_skew
                logic [REM-1:0] a_q;
                logic [REM-1:0] b_q;
                logic [REM-1:0] a_d;
                logic [REM-1:0] b_d;

                if (gi == 0) begin : g_in
                    assign a_d = A[WIDTH-1:DONE];
                    assign b_d = b_eff[WIDTH-1:DONE];
                end else begin : g_in
                    assign a_d = g_stage[gi-1].g_skew.a_q[REM+CHUNK-1:CHUNK];
                    assign b_d = g_stage[gi-1].g_skew.b_q[REM+CHUNK-1:CHUNK];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (advance && valid_d) begin
                        a_q <= a_d;
                        b_q <= b_d;
                    end
                end
            end
        end
    endgenerate

    // Carry into the MSB is recovered from the MSB's own sum bit rather than tapping the adder chain.
    assign v_d = g_stage[LAST].a_c[CHUNK-1] ^ g_stage[LAST].b_c[CHUNK-1]
               ^ g_stage[LAST].s_c[CHUNK-1] ^ g_stage[LAST].c_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= 1'b0;
        end else if (advance && g_stage[LAST].valid_d) begin
            v_q <= v_d;
        end
    end

    assign Y         = g_stage[LAST].sum_q;
    assign Cout      = g_stage[LAST].carry_q;
    assign V         = v_q;
    assign valid_out = g_stage[LAST].valid_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed, reset and randomized backpressure traffic against a queue model;
// extra STAGES=1 and STAGES=8 instances check latency of the basic add.
module tb_pipelined_adder;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       sub_r;
    logic       valid_in;
    logic       ready_out;
    logic       ready_in;
    logic [7:0] Y;
    logic       Cout;
    logic       V;
    logic       valid_out;

    logic       r1, c1, ov1, vo1;
    logic [7:0] y1;
    logic       r8, c8, ov8, vo8;
    logic [7:0] y8;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
`ifdef SUB_MODE_EN
        .sub(sub_r),
`endif
        .valid_in(valid_in), .ready_in(ready_in), .Y(Y), .Cout(Cout), .V(V),
        .valid_out(valid_out), .ready_out(ready_out)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
`ifdef SUB_MODE_EN
        .sub(sub_r),
`endif
        .valid_in(valid_in), .ready_in(r1), .Y(y1), .Cout(c1), .V(ov1),
        .valid_out(vo1), .ready_out(1'b1)
    );

    pipelined_adder #(.WIDTH(8), .STAGES(8)) dut8 (
        .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
`ifdef SUB_MODE_EN
        .sub(sub_r),
`endif
        .valid_in(valid_in), .ready_in(r8), .Y(y8), .Cout(c8), .V(ov8),
        .valid_out(vo8), .ready_out(1'b1)
    );

    typedef struct {
        logic [7:0] y;
        logic       c;
        logic       v;
        int         adv;
    } exp_t;

    exp_t       q[$];
    int         n_vec = 0;
    int         n_err = 0;
    logic       held = 1'b0;
    logic [9:0] hold_val;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic s);
        exp_t       e;
        int         u;
        int         sa;
        logic [7:0] nb;
        nb = ~b;
        if (s) begin
            u  = int'(a) + int'(nb) + (cin ? 0 : 1);
            sa = int'($signed(a)) - int'($signed(b)) - (cin ? 1 : 0);
        end else begin
            u  = int'(a) + int'(b) + (cin ? 1 : 0);
            sa = int'($signed(a)) + int'($signed(b)) + (cin ? 1 : 0);
        end
        e.y   = u[7:0];
        e.c   = u[8];
        e.v   = (sa > 127) || (sa < -128);
        e.adv = 0;
        return e;
    endfunction

    // One clock of traffic; the queue entry's adv counts how many stages it has travelled.
    task automatic cycle(input logic vin, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic s, input logic rdy, input logic use_const, input logic [9:0] cvy,
                         output logic acc);
        exp_t e;
        logic exp_vo;
        logic exp_adv;
        A = a; B = b; Cin = cin; sub_r = s; valid_in = vin; ready_out = rdy;
        #1;
        exp_vo  = (q.size() > 0) && (q[0].adv == S - 1);
        exp_adv = !exp_vo || rdy;
        chk("valid_out", valid_out, exp_vo);
        chk("ready_in", ready_in, exp_adv);
        if (held) chk("stall_hold", {Cout, V, Y}, hold_val);
        if (exp_vo) begin
            chk("sum_y", Y, q[0].y);
            chk("cout_v", {Cout, V}, {q[0].c, q[0].v});
            if (rdy) $display("out Y=%02h Cout=%b V=%b", Y, Cout, V);
        end
        held     = exp_vo && !rdy;
        hold_val = {Cout, V, Y};
        acc      = vin && exp_adv;
        if (acc) begin
            if (use_const) begin
                e.c = cvy[9]; e.v = cvy[8]; e.y = cvy[7:0]; e.adv = 0;
            end else begin
                e = model(a, b, cin, s);
            end
        end
        if (exp_adv) begin
            if (exp_vo) void'(q.pop_front());
            foreach (q[i]) q[i].adv++;
        end
        if (acc) q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc;
        logic rs;
        int   got;
        rst = 1'b1; A = '0; B = '0; Cin = 1'b0; sub_r = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_valid", valid_out, 1'b0);
        chk("reset_y", Y, 8'h00);
        chk("reset_cv", {Cout, V}, 2'b00);
        chk("reset_ready", ready_in, 1'b1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed corner cases streamed back to back
        cycle(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 8'h4B}, acc);
        cycle(1'b1, 8'h0F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 8'h10}, acc);
        cycle(1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, {1'b1, 1'b0, 8'h00}, acc);
        cycle(1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 8'h80}, acc);
        cycle(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 8'h00}, acc);
`ifdef SUB_MODE_EN
        cycle(1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 8'hFE}, acc);
`endif
        repeat (4) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, acc);

        // Reset with two items in flight
        cycle(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, acc);
        cycle(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, acc);
        rst = 1'b1;
        #1;
        chk("midrst_valid", valid_out, 1'b0);
        chk("midrst_y", Y, 8'h00);
        chk("midrst_cv", {Cout, V}, 2'b00);
        chk("midrst_ready", ready_in, 1'b1);
        q.delete();
        held = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, acc);

        // Random operands with random backpressure
        got = 0;
        for (int i = 0; i < 400 && got < 16; i++) begin
`ifdef SUB_MODE_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            cycle($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom), rs,
                  $urandom_range(0, 2) != 0, 1'b0, 10'h0, acc);
            if (acc) got++;
        end
        chk("rand_accepted", got, 16);
        for (int i = 0; i < 20 && q.size() > 0; i++)
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, acc);
        chk("drain_empty", q.size(), 0);

        // Latency of the basic add at STAGES=1 and STAGES=8
        repeat (10) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, acc);
        cycle(1'b1, 8'h3C, 8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 8'h4B}, acc);
        for (int k = 1; k <= 9; k++) begin
            chk("lat1_valid", vo1, k == 1);
            chk("lat8_valid", vo8, k == 8);
            if (k == 1) chk("lat1_sum", {c1, ov1, y1}, {2'b00, 8'h4B});
            if (k == 8) chk("lat8_sum", {c8, ov8, y8}, {2'b00, 8'h4B});
            cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0, acc);
        end
        chk("final_empty", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
